// File: rtl/prio_q_arbiter.sv
// rtl/prio_q_arbiter.sv - round-robin arbiter sharing one heap priority queue among cores
// Grants one enq / deq / replace per issue slot, bypasses the queue when legal, returns dequeued minimums.
module prio_q_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DWIDTH    = 16,
  parameter int CNT_W     = 5,
  parameter int Q_GAP     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        req_enq,
  input  logic [NUM_CORES-1:0]        req_deq,
  input  logic [NUM_CORES*DWIDTH-1:0] req_data,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]           rsp_data,
  output logic                        q_enq,
  output logic                        q_deq,
  output logic [DWIDTH-1:0]           q_inp_data,
  input  logic [DWIDTH-1:0]           q_out_data,
  input  logic                        q_full,
  input  logic                        q_empty,
  input  logic [CNT_W-1:0]            q_elem_cnt,
  output logic                        busy
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int GW = (Q_GAP > 1) ? $clog2(Q_GAP) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, rr_ptr_nxt, win, win_nxt, sel;
  logic [GW-1:0]         gap_cnt, gap_nxt;
  logic                  has_deq, has_deq_nxt, bypass, bypass_nxt, found, sel_bypass;
  logic [DWIDTH-1:0]     data_l, data_nxt, sel_data, rsp_data_nxt, q_inp_nxt;
  logic [NUM_CORES-1:0]  elig, gnt_nxt, rsp_valid_nxt;
  logic                  q_enq_nxt, q_deq_nxt;
  logic                  unused_cnt;

  assign unused_cnt = ^q_elem_cnt;

  // Combined enq+deq is always serviceable: it either replaces the head or bypasses.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = req[i] & ((req_enq[i] & req_deq[i]) |
                          (req_enq[i] & ~req_deq[i] & ~q_full) |
                          (~req_enq[i] & req_deq[i] & ~q_empty));
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign sel_data   = req_data[sel*DWIDTH +: DWIDTH];
  assign sel_bypass = req_enq[sel] & req_deq[sel] & (q_empty | (sel_data <= q_out_data));

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    gap_nxt       = gap_cnt;
    win_nxt       = win;
    has_deq_nxt   = has_deq;
    bypass_nxt    = bypass;
    data_nxt      = data_l;
    gnt_nxt       = '0;
    rsp_valid_nxt = '0;
    rsp_data_nxt  = rsp_data;
    q_enq_nxt     = 1'b0;
    q_deq_nxt     = 1'b0;
    q_inp_nxt     = q_inp_data;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = ISSUE;
          win_nxt       = sel;
          data_nxt      = sel_data;
          has_deq_nxt   = req_deq[sel];
          bypass_nxt    = sel_bypass;
          gnt_nxt[sel]  = 1'b1;
          q_enq_nxt     = req_enq[sel] & ~sel_bypass;
          q_deq_nxt     = req_deq[sel] & ~sel_bypass;
          q_inp_nxt     = sel_data;
        end
      end
      ISSUE: begin
        state_nxt          = GAP;
        gap_nxt            = GW'(Q_GAP - 1);
        rsp_valid_nxt[win] = has_deq;
        rsp_data_nxt       = bypass ? data_l : q_out_data;
        rr_ptr_nxt         = (win == PW'(NUM_CORES - 1)) ? '0 : win + 1'b1;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gap_cnt    <= '0;
      win        <= '0;
      has_deq    <= 1'b0;
      bypass     <= 1'b0;
      data_l     <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      q_enq      <= 1'b0;
      q_deq      <= 1'b0;
      q_inp_data <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      gap_cnt    <= gap_nxt;
      win        <= win_nxt;
      has_deq    <= has_deq_nxt;
      bypass     <= bypass_nxt;
      data_l     <= data_nxt;
      gnt        <= gnt_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      q_enq      <= q_enq_nxt;
      q_deq      <= q_deq_nxt;
      q_inp_data <= q_inp_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_prio_q_arbiter.sv
// tb/tb_prio_q_arbiter.sv - directed bench for prio_q_arbiter with a sorted-list queue stand-in
module tb_prio_q_arbiter;
  localparam int N = 4, DW = 16, CW = 5, QG = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req, req_enq, req_deq, gnt, rsp_valid;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] rsp_data, q_inp_data;
  logic [DW-1:0] q_out_data = '0;
  logic q_enq, q_deq, busy;
  logic q_full = 1'b0, q_empty = 1'b1;
  logic [CW-1:0] q_elem_cnt = '0;
  logic clr_req = 1'b0, fill_req = 1'b0;
  int n_checks = 0, n_fail = 0, cyc = 0, viol = 0, oh_viol = 0;
  int unsigned qm[$];

  prio_q_arbiter #(.NUM_CORES(N), .DWIDTH(DW), .CNT_W(CW), .Q_GAP(QG)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_enq(req_enq), .req_deq(req_deq),
    .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .q_enq(q_enq), .q_deq(q_deq), .q_inp_data(q_inp_data), .q_out_data(q_out_data),
    .q_full(q_full), .q_empty(q_empty), .q_elem_cnt(q_elem_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Queue stand-in: ascending list, capacity 31, head is the minimum.
  always @(posedge clk) begin
    int pos;
    pos = 0;
    if (clr_req) qm.delete();
    else if (fill_req) begin
      qm.delete();
      for (int i = 0; i < 31; i++) qm.push_back(100 + i);
    end else begin
      if (q_deq) begin
        if (qm.size() == 0) viol++;
        else void'(qm.pop_front());
      end
      if (q_enq) begin
        while (pos < qm.size() && qm[pos] <= 32'(q_inp_data)) pos++;
        qm.insert(pos, 32'(q_inp_data));
      end
    end
    q_elem_cnt <= CW'(qm.size());
    q_empty    <= (qm.size() == 0);
    q_full     <= (qm.size() >= 31);
    q_out_data <= (qm.size() == 0) ? '0 : DW'(qm[0]);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      if (!$onehot0(gnt) || !$onehot0(rsp_valid) || (gnt != '0 && rsp_valid != '0 && gnt != rsp_valid))
        oh_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int c, input logic r, input logic e, input logic d, input logic [DW-1:0] v);
    req[c] = r;
    req_enq[c] = e;
    req_deq[c] = d;
    req_data[c*DW +: DW] = v;
  endtask

  task automatic wait_gnt(input string tag, output int idx);
    int n;
    n = 0;
    idx = -1;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 60);
    if (gnt == '0) check({tag, "_timeout"}, 32'd1, 32'd0);
    else for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
  endtask

  task automatic clear_q();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int idx, seen;
    int t[4];
    logic [DW-1:0] d[4];
    logic [DW-1:0] exp_deq[4];
    d = '{16'd40, 16'd10, 16'd30, 16'd20};
    exp_deq = '{16'd10, 16'd20, 16'd30, 16'd40};
    req = '0; req_enq = '0; req_deq = '0; req_data = '0;

    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_q_enq", q_enq, 0);
    check("rst_q_deq", q_deq, 0);
    check("rst_q_inp_data", q_inp_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b0;

    // reset asserted while core 1's dequeue is in ISSUE
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    drive(1, 1, 0, 1, 0);
    wait_gnt("midrst", idx);
    check("midrst_idx", idx, 1);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0 || gnt != '0) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", q_elem_cnt, 31);
    clear_q();

    // four enq-only together: order from rr_ptr=0, spacing 2+Q_GAP
    for (int c = 0; c < N; c++) drive(c, 1, 1, 0, d[c]);
    for (int k = 0; k < N; k++) begin
      wait_gnt("enq", idx);
      t[k] = cyc;
      check("enq_order", idx, k);
      check("enq_q_enq", q_enq, 1);
      check("enq_q_deq", q_deq, 0);
      check("enq_data", q_inp_data, d[k]);
      if (k > 0) check("enq_spacing", t[k] - t[k-1], 2 + QG);
      if (idx >= 0) drive(idx, 0, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    check("enq_cnt", q_elem_cnt, 4);

    // core 2 deq-only four times
    for (int k = 0; k < 4; k++) begin
      drive(2, 1, 0, 1, 0);
      wait_gnt("deq", idx);
      check("deq_idx", idx, 2);
      check("deq_q_deq", q_deq, 1);
      check("deq_q_enq", q_enq, 0);
      drive(2, 0, 0, 0, 0);
      @(negedge clk);
      check("deq_rsp_valid", rsp_valid, 4'b0100);
      check("deq_rsp_data", rsp_data, exp_deq[k]);
    end
    repeat (3) @(negedge clk);
    check("deq_empty", q_empty, 1);

    // enq+deq on empty queue: bypass
    drive(1, 1, 1, 1, 16'd7);
    wait_gnt("byp_empty", idx);
    check("byp_empty_idx", idx, 1);
    check("byp_empty_q_enq", q_enq, 0);
    check("byp_empty_q_deq", q_deq, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("byp_empty_rsp_valid", rsp_valid, 4'b0010);
    check("byp_empty_rsp_data", rsp_data, 7);

    drive(0, 1, 1, 0, 16'd5);
    wait_gnt("head5", idx);
    check("head5_idx", idx, 0);
    drive(0, 0, 0, 0, 0);

    // replace: 9 > head 5
    drive(1, 1, 1, 1, 16'd9);
    wait_gnt("repl", idx);
    check("repl_idx", idx, 1);
    check("repl_q_enq", q_enq, 1);
    check("repl_q_deq", q_deq, 1);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("repl_rsp_data", rsp_data, 5);
    repeat (2) @(negedge clk);
    check("repl_cnt", q_elem_cnt, 1);
    check("repl_head", q_out_data, 9);

    // equal to head still bypasses
    drive(1, 1, 1, 1, 16'd9);
    wait_gnt("byp_eq", idx);
    check("byp_eq_q_enq", q_enq, 0);
    check("byp_eq_q_deq", q_deq, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("byp_eq_rsp_data", rsp_data, 9);
    check("byp_eq_rsp_valid", rsp_valid, 4'b0010);

    // core 3 op moves rr_ptr to 0, then full queue
    drive(3, 1, 1, 0, 16'd50);
    wait_gnt("ptr3", idx);
    check("ptr3_idx", idx, 3);
    drive(3, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    @(negedge clk);
    check("full_flag", q_full, 1);
    drive(0, 1, 1, 0, 16'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (gnt != '0) seen++;
    end
    check("full_no_gnt", seen, 0);
    drive(3, 1, 0, 1, 0);
    wait_gnt("full_deq", idx);
    check("full_deq_idx", idx, 3);
    drive(3, 0, 0, 0, 0);
    @(negedge clk);
    check("full_deq_rsp", rsp_data, 100);
    wait_gnt("full_enq", idx);
    check("full_enq_idx", idx, 0);
    check("full_enq_data", q_inp_data, 1);
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("full_cnt", q_elem_cnt, 31);

    // empty queue: deq waits until core 0's enq lands
    clear_q();
    drive(2, 1, 0, 1, 0);
    drive(0, 1, 1, 0, 16'd12);
    wait_gnt("emp_enq", idx);
    check("emp_enq_idx", idx, 0);
    drive(0, 0, 0, 0, 0);
    wait_gnt("emp_deq", idx);
    check("emp_deq_idx", idx, 2);
    check("emp_deq_q_deq", q_deq, 1);
    drive(2, 0, 0, 0, 0);
    @(negedge clk);
    check("emp_deq_rsp_valid", rsp_valid, 4'b0100);
    check("emp_deq_rsp_data", rsp_data, 12);
    repeat (4) @(negedge clk);

    check("deq_while_empty", viol, 0);
    check("onehot_overlap", oh_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
